serv_bufreg_seq: RTL and testbench

- Sequencer for the bit-serial buffer register (address/shift-operand register) and its data-bus access.
- Generates the 32-cycle enable/init/count strobes that shift rs1+imm into the buffer register and checks alignment of the resulting address.
- Issues the data-bus cycle for load/store instructions, then runs the 32-cycle execute pass.
- Sits between decode (start, op class) and the bufreg/dbus datapath.

---
 rtl/serv_bufreg_seq.sv | 119 +++++++++++
 tb/tb_serv_bufreg_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_bufreg_seq.sv
// rtl/serv_bufreg_seq.sv - bit-serial buffer register and data-bus access sequencer
module serv_bufreg_seq #(
  parameter int W         = 1,
  parameter bit ALIGN_CHK = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_two_stage,
  input  logic       i_mem_op,
  input  logic       i_word,
  input  logic       i_half,
  input  logic [1:0] i_lsb,
  input  logic       i_stall,
  input  logic       i_dbus_ack,
  output logic       o_busy,
  output logic       o_en,
  output logic       o_init,
  output logic [4:0] o_cnt,
  output logic       o_cnt0,
  output logic       o_cnt1,
  output logic       o_dbus_cyc,
  output logic       o_trap,
  output logic       o_done
);

  // The counter and strobes assume one bit per cycle; wider paths are not built.
  if (W != 1) begin : g_bad_width
    $error("serv_bufreg_seq: only W=1 is supported");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_CHK  = 3'd2,
    S_MEM  = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  logic en;
  logic cnt_last;
  logic misalign;

  // Serial progress only in the two shifting phases, and never while stalled.
  assign en       = ((state_q == S_INIT) || (state_q == S_RUN)) && !i_stall;
  assign cnt_last = (cnt_q == 5'd31);
  // i_lsb is the bufreg's low address bits, stable once the INIT pass is over.
  assign misalign = ALIGN_CHK & i_mem_op & ((i_word & (|i_lsb)) | (i_half & i_lsb[0]));

  // State and bit counter registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = i_two_stage ? S_INIT : S_RUN;
          cnt_d   = 5'd0;
        end
      end
      S_INIT: begin
        if (en) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_last) state_d = S_CHK;
        end
      end
      S_CHK: begin
        cnt_d = 5'd0;
        if (misalign)      state_d = S_IDLE;
        else if (i_mem_op) state_d = S_MEM;
        else               state_d = S_RUN;
      end
      S_MEM: begin
        if (i_dbus_ack) begin
          state_d = S_RUN;
          cnt_d   = 5'd0;
        end
      end
      S_RUN: begin
        if (en) begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_last) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Output decode; strobes are gated by the shift enable so stalls hide them.
  always_comb begin
    o_busy     = (state_q != S_IDLE);
    o_en       = en;
    o_init     = (state_q == S_INIT);
    o_cnt      = cnt_q;
    o_cnt0     = en && (cnt_q == 5'd0);
    o_cnt1     = en && (cnt_q == 5'd1);
    o_dbus_cyc = (state_q == S_MEM);
    o_trap     = (state_q == S_CHK) && misalign;
    o_done     = (state_q == S_RUN) && en && cnt_last;
  end

endmodule

// File: tb/tb_serv_bufreg_seq.sv
// tb/tb_serv_bufreg_seq.sv - directed self-checking bench for serv_bufreg_seq
module tb_serv_bufreg_seq;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_start;
  logic       i_two_stage;
  logic       i_mem_op;
  logic       i_word;
  logic       i_half;
  logic [1:0] i_lsb;
  logic       i_stall;
  logic       i_dbus_ack;

  logic       o_busy, o_en, o_init, o_cnt0, o_cnt1, o_dbus_cyc, o_trap, o_done;
  logic [4:0] o_cnt;
  logic       z_busy, z_en, z_init, z_cnt0, z_cnt1, z_dbus_cyc, z_trap, z_done;
  logic [4:0] z_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_clk = ~i_clk;

  serv_bufreg_seq #(.W(1), .ALIGN_CHK(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_two_stage(i_two_stage),
    .i_mem_op(i_mem_op), .i_word(i_word), .i_half(i_half), .i_lsb(i_lsb),
    .i_stall(i_stall), .i_dbus_ack(i_dbus_ack),
    .o_busy(o_busy), .o_en(o_en), .o_init(o_init), .o_cnt(o_cnt),
    .o_cnt0(o_cnt0), .o_cnt1(o_cnt1), .o_dbus_cyc(o_dbus_cyc),
    .o_trap(o_trap), .o_done(o_done)
  );

  serv_bufreg_seq #(.W(1), .ALIGN_CHK(1'b0)) dut_nochk (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_two_stage(i_two_stage),
    .i_mem_op(i_mem_op), .i_word(i_word), .i_half(i_half), .i_lsb(i_lsb),
    .i_stall(i_stall), .i_dbus_ack(i_dbus_ack),
    .o_busy(z_busy), .o_en(z_en), .o_init(z_init), .o_cnt(z_cnt),
    .o_cnt0(z_cnt0), .o_cnt1(z_cnt1), .o_dbus_cyc(z_dbus_cyc),
    .o_trap(z_trap), .o_done(z_done)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_start = 0; i_two_stage = 0; i_mem_op = 0; i_word = 0; i_half = 0;
    i_lsb = 2'b00; i_stall = 0; i_dbus_ack = 0;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    idle_inputs();
    i_rst = 1;
    tick(); tick();
    i_rst = 0;
    #1;
    got = {o_busy, o_en, o_init, o_cnt0, o_cnt1, o_dbus_cyc, o_trap, o_done, |o_cnt};
    n_checks++;
    if (got !== 9'd0) $display("FAIL reset_outputs got=%b exp=%b", got, 9'd0);
    else n_pass++;
    // start a two-stage op, then reset it mid-INIT at cnt=17
    i_start = 1; i_two_stage = 1;
    tick();
    i_start = 0;
    repeat (17) tick();
    n_checks++;
    if (o_cnt !== 5'd17 || o_init !== 1'b1)
      $display("FAIL reset_pre_cnt got cnt=%0d init=%b exp cnt=17 init=1", o_cnt, o_init);
    else n_pass++;
    i_rst = 1;
    #1;
    n_checks++;
    if (o_done !== 1'b0 || o_trap !== 1'b0)
      $display("FAIL reset_no_pulse got done=%b trap=%b exp 0 0", o_done, o_trap);
    else n_pass++;
    tick();
    i_rst = 0;
    #1;
    got = {o_busy, o_en, o_init, o_cnt0, o_cnt1, o_dbus_cyc, o_trap, o_done, |o_cnt};
    n_checks++;
    if (got !== 9'd0) $display("FAIL reset_mid_init got=%b exp=%b", got, 9'd0);
    else n_pass++;
    i_two_stage = 0;
  endtask

  task automatic test_single();
    idle_inputs();
    i_start = 1;
    tick();
    i_start = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      n_checks++;
      if (o_en !== 1'b1 || o_init !== 1'b0 || o_cnt !== 5'(i) ||
          o_cnt0 !== (i == 0) || o_cnt1 !== (i == 1) || o_done !== (i == 31))
        $display("FAIL single_cyc%0d got en=%b init=%b cnt=%0d c0=%b c1=%b done=%b exp en=1 init=0 cnt=%0d c0=%b c1=%b done=%b",
                 i, o_en, o_init, o_cnt, o_cnt0, o_cnt1, o_done, i, (i == 0), (i == 1), (i == 31));
      else n_pass++;
      tick();
    end
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL single_idle got busy=%b exp=0", o_busy);
    else n_pass++;
  endtask

  task automatic test_two_stage_load();
    int total, n_init, n_dbus, n_chk, n_en;
    bit seen_done;
    idle_inputs();
    i_two_stage = 1; i_mem_op = 1; i_word = 1; i_lsb = 2'b00;
    i_start = 1;
    tick();
    i_start = 0;
    total = 0; n_init = 0; n_dbus = 0; n_chk = 0; n_en = 0; seen_done = 0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      total++;
      if (o_init) n_init++;
      if (o_en) n_en++;
      if (o_busy && !o_en && !o_dbus_cyc) n_chk++;
      if (o_dbus_cyc) begin
        n_dbus++;
        i_dbus_ack = (n_dbus == 4);
      end else begin
        i_dbus_ack = 0;
      end
      #1;
      if (o_done) seen_done = 1;
      tick();
    end
    i_dbus_ack = 0;
    n_checks++;
    if (!seen_done || total != 69)
      $display("FAIL load_total got done=%b cycles=%0d exp done=1 cycles=69", seen_done, total);
    else n_pass++;
    n_checks++;
    if (n_init != 32 || n_chk != 1 || n_dbus != 4 || n_en != 64)
      $display("FAIL load_phases got init=%0d chk=%0d dbus=%0d en=%0d exp 32 1 4 64",
               n_init, n_chk, n_dbus, n_en);
    else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0 || o_dbus_cyc !== 1'b0)
      $display("FAIL load_idle got busy=%b dbus=%b exp 0 0", o_busy, o_dbus_cyc);
    else n_pass++;
  endtask

  task automatic test_misalign();
    int trap_cyc, n_trap, n_dbus, z_ntrap, z_wait;
    bit z_seen_done;
    idle_inputs();
    i_two_stage = 1; i_mem_op = 1; i_half = 1; i_lsb = 2'b01;
    i_start = 1;
    tick();
    i_start = 0;
    trap_cyc = -1; n_trap = 0; n_dbus = 0; z_ntrap = 0;
    for (int c = 0; c < 34; c++) begin
      #1;
      if (o_trap) begin
        n_trap++;
        trap_cyc = c;
        n_checks++;
        if (o_en !== 1'b0 || o_dbus_cyc !== 1'b0 || o_done !== 1'b0)
          $display("FAIL trap_chk_outputs got en=%b dbus=%b done=%b exp 0 0 0", o_en, o_dbus_cyc, o_done);
        else n_pass++;
      end
      if (o_dbus_cyc) n_dbus++;
      if (z_trap) z_ntrap++;
      tick();
    end
    n_checks++;
    if (n_trap != 1 || trap_cyc != 32)
      $display("FAIL trap_pulse got count=%0d cycle=%0d exp count=1 cycle=32", n_trap, trap_cyc);
    else n_pass++;
    n_checks++;
    if (n_dbus != 0 || o_busy !== 1'b0)
      $display("FAIL trap_no_dbus got dbus_cycles=%0d busy=%b exp 0 0", n_dbus, o_busy);
    else n_pass++;
    // the unchecked instance went through CHK at the same time and now sits in MEM
    n_checks++;
    if (z_ntrap != 0 || z_dbus_cyc !== 1'b1)
      $display("FAIL nochk_mem got traps=%0d dbus=%b exp 0 1", z_ntrap, z_dbus_cyc);
    else n_pass++;
    i_dbus_ack = 1;
    tick();
    i_dbus_ack = 0;
    z_seen_done = 0; z_wait = 0;
    for (int c = 0; c < 40 && !z_seen_done; c++) begin
      #1;
      z_wait++;
      if (z_done) z_seen_done = 1;
      tick();
    end
    n_checks++;
    if (!z_seen_done || z_wait != 32 || z_busy !== 1'b0)
      $display("FAIL nochk_run got done=%b cycles=%0d busy=%b exp 1 32 0", z_seen_done, z_wait, z_busy);
    else n_pass++;
  endtask

  task automatic test_stall();
    int total, exp_cnt;
    bit stalled31, seen_done;
    idle_inputs();
    i_start = 1;
    tick();
    i_start = 0;
    total = 0; exp_cnt = 0; stalled31 = 0; seen_done = 0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      i_stall = (c < 2) || (o_cnt == 5'd31 && !stalled31);
      if (o_cnt == 5'd31 && i_stall) stalled31 = 1;
      #1;
      total++;
      n_checks++;
      if (o_cnt !== 5'(exp_cnt) ||
          (i_stall && (o_en !== 1'b0 || o_cnt0 !== 1'b0 || o_done !== 1'b0)) ||
          (!i_stall && o_en !== 1'b1))
        $display("FAIL stall_cyc%0d got cnt=%0d en=%b c0=%b done=%b stall=%b exp cnt=%0d",
                 c, o_cnt, o_en, o_cnt0, o_done, i_stall, exp_cnt);
      else n_pass++;
      if (o_done) seen_done = 1;
      if (!i_stall) exp_cnt = (exp_cnt + 1) % 32;
      tick();
    end
    i_stall = 0;
    n_checks++;
    if (!seen_done || total != 35)
      $display("FAIL stall_latency got done=%b cycles=%0d exp 1 35", seen_done, total);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int total;
    bit seen_done;
    idle_inputs();
    i_start = 1;
    tick();
    total = 0; seen_done = 0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      i_dbus_ack = (c == 5);
      #1;
      total++;
      if (c == 5) begin
        n_checks++;
        if (o_dbus_cyc !== 1'b0 || o_cnt !== 5'd5)
          $display("FAIL b2b_spurious_ack got dbus=%b cnt=%0d exp 0 5", o_dbus_cyc, o_cnt);
        else n_pass++;
      end
      if (o_done) seen_done = 1;
      tick();
    end
    i_dbus_ack = 0;
    n_checks++;
    if (!seen_done || total != 32)
      $display("FAIL b2b_first got done=%b cycles=%0d exp 1 32", seen_done, total);
    else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0)
      $display("FAIL b2b_gap got busy=%b exp 0", o_busy);
    else n_pass++;
    tick();
    n_checks++;
    if (o_busy !== 1'b1 || o_cnt !== 5'd0 || o_cnt0 !== 1'b1 || o_init !== 1'b0)
      $display("FAIL b2b_restart got busy=%b cnt=%0d c0=%b init=%b exp 1 0 1 0",
               o_busy, o_cnt, o_cnt0, o_init);
    else n_pass++;
    i_start = 0;
    i_rst = 1;
    tick();
    i_rst = 0;
  endtask

  initial begin
    idle_inputs();
    i_rst = 1;
    test_reset();
    test_single();
    test_two_stage_load();
    test_misalign();
    test_stall();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
